// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS-subset sequencer with per-state datapath strobes
// Optional JUMP_EN macro adds the JUMP state and decodes opcode 000010 as j.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       zext,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ORI = 6'b001101;
`ifdef JUMP_EN
  localparam logic [5:0] OP_J   = 6'b000010;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_ORIEX  = 4'd9,
    S_ORIWB  = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t cur;

  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= S_FETCH;
    end else begin
      case (cur)
        S_FETCH:  if (mem_ready) cur <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_R:          cur <= S_EXEC;
            OP_LW, OP_SW:  cur <= S_MEMADR;
            OP_BEQ:        cur <= S_BRANCH;
            OP_ORI:        cur <= S_ORIEX;
`ifdef JUMP_EN
            OP_J:          cur <= S_JUMP;
`endif
            default:       cur <= S_FETCH;
          endcase
        end
        // Only lw reaches here as anything but sw, so lw is the fallback.
        S_MEMADR: cur <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
        S_MEMWB:  cur <= S_FETCH;
        S_MEMWR:  if (mem_ready) cur <= S_FETCH;
        S_EXEC:   cur <= S_RWB;
        S_RWB:    cur <= S_FETCH;
        S_BRANCH: cur <= S_FETCH;
        S_ORIEX:  cur <= S_ORIWB;
        S_ORIWB:  cur <= S_FETCH;
`ifdef JUMP_EN
        S_JUMP:   cur <= S_FETCH;
`endif
        default:  cur <= S_FETCH;
      endcase
    end
  end

  logic opcode_known;
  logic pcsource_hi;
  logic pcsource_lo;

  always_comb begin
    opcode_known = (opcode == OP_R) || (opcode == OP_LW) || (opcode == OP_SW) ||
                   (opcode == OP_BEQ) || (opcode == OP_ORI);
`ifdef JUMP_EN
    if (opcode == OP_J) opcode_known = 1'b1;
`endif
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    zext        = 1'b0;
    aluop       = 2'b00;
    pcsource_hi = 1'b0;
    pcsource_lo = 1'b0;
    illegal     = 1'b0;
    case (cur)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        pcwrite = mem_ready;
        irwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = ~opcode_known;
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource_lo = 1'b1;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        zext    = 1'b1;
        aluop   = 2'b11;
      end
      S_ORIWB: regwrite = 1'b1;
`ifdef JUMP_EN
      S_JUMP: begin
        pcwrite     = 1'b1;
        pcsource_hi = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef JUMP_EN
  assign pcsource = {pcsource_hi, pcsource_lo};
`else
  logic unused_pcsource_hi;
  assign unused_pcsource_hi = pcsource_hi;
  assign pcsource = {1'b0, pcsource_lo};
`endif

  assign state = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
// Expected controls are hand-packed constants per state; JUMP_EN selects the j expectations.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, zext, illegal;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
    .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
    .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .zext(zext), .aluop(aluop),
    .pcsource(pcsource), .illegal(illegal), .state(state)
  );

  // pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,alusrca,alusrcb,zext,aluop,pcsource,illegal
  logic [17:0] ctl;
  assign ctl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, zext, aluop, pcsource, illegal};

  localparam logic [17:0] C_FR   = 18'b1_0_0_1_0_1_0_0_0_0_01_0_00_00_0;
  localparam logic [17:0] C_FW   = 18'b0_0_0_1_0_0_0_0_0_0_01_0_00_00_0;
  localparam logic [17:0] C_DEC  = 18'b0_0_0_0_0_0_0_0_0_0_11_0_00_00_0;
  localparam logic [17:0] C_DECI = 18'b0_0_0_0_0_0_0_0_0_0_11_0_00_00_1;
  localparam logic [17:0] C_MA   = 18'b0_0_0_0_0_0_0_0_0_1_10_0_00_00_0;
  localparam logic [17:0] C_MR   = 18'b0_0_1_1_0_0_0_0_0_0_00_0_00_00_0;
  localparam logic [17:0] C_WB   = 18'b0_0_0_0_0_0_1_0_1_0_00_0_00_00_0;
  localparam logic [17:0] C_MW   = 18'b0_0_1_0_1_0_0_0_0_0_00_0_00_00_0;
  localparam logic [17:0] C_EX   = 18'b0_0_0_0_0_0_0_0_0_1_00_0_10_00_0;
  localparam logic [17:0] C_RWB  = 18'b0_0_0_0_0_0_0_1_1_0_00_0_00_00_0;
  localparam logic [17:0] C_BR   = 18'b0_1_0_0_0_0_0_0_0_1_00_0_01_01_0;
  localparam logic [17:0] C_OEX  = 18'b0_0_0_0_0_0_0_0_0_1_10_1_11_00_0;
  localparam logic [17:0] C_OWB  = 18'b0_0_0_0_0_0_0_0_1_0_00_0_00_00_0;
  localparam logic [17:0] C_JMP  = 18'b1_0_0_0_0_0_0_0_0_0_00_0_00_10_0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ORI = 6'b001101, J = 6'b000010, BAD = 6'b111111;

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b expected=%b", tag, got, exp);
    end
  endtask

  // Drive inputs on the falling edge, then check the state and controls ahead of the next rise.
  task automatic step(input string tag, input logic rst, input logic [5:0] opc,
                      input logic rdy, input logic [3:0] es, input logic [17:0] ec);
    @(negedge clk);
    reset = rst;
    opcode = opc;
    mem_ready = rdy;
    #1;
    check({tag, "_st"}, {14'd0, state}, {14'd0, es});
    check({tag, "_ctl"}, ctl, ec);
  endtask

  initial begin
    reset = 1'b1;
    opcode = BAD;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    step("rst", 1'b1, BAD, 1'b1, 4'd0, C_FR);

    // lw, zero wait states: 0,1,2,3,4 then FETCH
    step("lw_f",  1'b0, BAD, 1'b1, 4'd0, C_FR);
    step("lw_d",  1'b0, LW,  1'b1, 4'd1, C_DEC);
    step("lw_ma", 1'b0, LW,  1'b0, 4'd2, C_MA);
    step("lw_mr", 1'b0, R,   1'b1, 4'd3, C_MR);
    step("lw_wb", 1'b0, SW,  1'b0, 4'd4, C_WB);

    // R-type with three wait cycles in FETCH
    step("r_fw0", 1'b0, BEQ, 1'b0, 4'd0, C_FW);
    step("r_fw1", 1'b0, BEQ, 1'b0, 4'd0, C_FW);
    step("r_fw2", 1'b0, BEQ, 1'b0, 4'd0, C_FW);
    step("r_fr",  1'b0, BEQ, 1'b1, 4'd0, C_FR);
    step("r_d",   1'b0, R,   1'b0, 4'd1, C_DEC);
    step("r_ex",  1'b0, LW,  1'b1, 4'd6, C_EX);
    step("r_wb",  1'b0, LW,  1'b1, 4'd7, C_RWB);

    // sw with two wait cycles in MEMWR
    step("sw_f",  1'b0, R,   1'b1, 4'd0, C_FR);
    step("sw_d",  1'b0, SW,  1'b1, 4'd1, C_DEC);
    step("sw_ma", 1'b0, SW,  1'b1, 4'd2, C_MA);
    step("sw_w0", 1'b0, LW,  1'b0, 4'd5, C_MW);
    step("sw_w1", 1'b0, LW,  1'b0, 4'd5, C_MW);
    step("sw_w2", 1'b0, LW,  1'b1, 4'd5, C_MW);

    // beq then ori
    step("beq_f", 1'b0, R,   1'b1, 4'd0, C_FR);
    step("beq_d", 1'b0, BEQ, 1'b1, 4'd1, C_DEC);
    step("beq_b", 1'b0, ORI, 1'b1, 4'd8, C_BR);
    step("ori_f", 1'b0, R,   1'b1, 4'd0, C_FR);
    step("ori_d", 1'b0, ORI, 1'b0, 4'd1, C_DEC);
    step("ori_x", 1'b0, SW,  1'b1, 4'd9, C_OEX);
    step("ori_w", 1'b0, SW,  1'b1, 4'd10, C_OWB);

    // unsupported opcode: single illegal pulse in DECODE
    step("bad_f", 1'b0, R,   1'b1, 4'd0, C_FR);
    step("bad_d", 1'b0, BAD, 1'b1, 4'd1, C_DECI);
    step("bad_f2", 1'b0, R,  1'b0, 4'd0, C_FW);
    step("bad_f3", 1'b0, R,  1'b1, 4'd0, C_FR);

`ifdef JUMP_EN
    step("j_d",   1'b0, J,   1'b1, 4'd1, C_DEC);
    step("j_j",   1'b0, BAD, 1'b1, 4'd11, C_JMP);
`else
    step("j_d",   1'b0, J,   1'b1, 4'd1, C_DECI);
`endif

    // reset in the middle of a MEMRD wait, with mem_ready also high
    step("rs_f",  1'b0, R,   1'b1, 4'd0, C_FR);
    step("rs_d",  1'b0, LW,  1'b1, 4'd1, C_DEC);
    step("rs_ma", 1'b0, LW,  1'b1, 4'd2, C_MA);
    step("rs_mw", 1'b0, LW,  1'b0, 4'd3, C_MR);
    step("rs_ar", 1'b1, LW,  1'b1, 4'd3, C_MR);
    step("rs_f0", 1'b0, LW,  1'b0, 4'd0, C_FW);
    step("rs_f1", 1'b0, LW,  1'b1, 4'd0, C_FR);
    step("rs_d2", 1'b0, R,   1'b1, 4'd1, C_DEC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
